// File: rtl/sipo_rx_ctrl.sv
// Frame-level serial-in/parallel-out receiver: arms on frame_start, shifts WIDTH
// qualified bits MSB-first, and hands the word to a one-entry valid/ready buffer.
module sipo_rx_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             load;
  logic             drop;

  assign word = {sreg[WIDTH-2:0], serial_in};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    cnt_n    = bit_cnt;
    complete = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_n = SHIFT;
          sreg_n  = '0;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        // A restart strobe beats a coincident final bit.
        if (frame_start) begin
          sreg_n = '0;
          cnt_n  = '0;
        end else if (bit_valid) begin
          sreg_n = word;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            complete = 1'b1;
            state_n  = IDLE;
            cnt_n    = '0;
          end else begin
            cnt_n = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The buffer accepts a new word when empty or when it drains in the same cycle.
  assign load = complete && (!out_valid || out_ready);
  assign drop = complete && out_valid && !out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      bit_cnt <= cnt_n;
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
Frame-level controller for the serial-in/parallel-out shift path. It owns a WIDTH-bit shift register and sequences it: arms on a frame-start strobe, shifts exactly WIDTH qualified bits, then hands the assembled word to a downstream consumer through a one-entry valid/ready output buffer. It sits between a serial bit source (bring-up pin or UART-style sampler) and any parallel consumer. It also flags frames lost to back-pressure.

Parameters:
WIDTH, 8, bits per frame and width of the shift register and output word (≥2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset, sampled on rising clk
frame_start  input  1  one-cycle strobe that starts a new frame (or aborts and restarts one in progress)
serial_in  input  1  serial data bit
bit_valid  input  1  serial_in is valid this cycle; sampled only in SHIFT
out_data  output  WIDTH  assembled word, held stable while out_valid=1
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
busy  output  1  1 while in SHIFT
bit_cnt  output  CNT_W  bits accepted in the current frame
overrun  output  1  sticky: a completed word was dropped
clr_overrun  input  1  clears overrun

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, shift reg=0, bit_cnt=0, out_data=0, out_valid=0, busy=0, overrun=0. Reset in the middle of a frame discards it. Reset overrides every other input.
- FSM has two states, IDLE and SHIFT.
- IDLE: bit_valid is ignored. frame_start=1 moves to SHIFT next cycle with bit_cnt=0. No bit is sampled in the frame_start cycle.
- SHIFT: busy=1. Each cycle with bit_valid=1:
  - sreg <= {sreg[WIDTH-2:0], serial_in}. The new bit enters bit 0, so the first received bit ends in the MSB.
  - bit_cnt increments.
- Frame completion: the cycle in which the WIDTH-th bit is accepted is the completion cycle.
  - The word {sreg[WIDTH-2:0], serial_in} is offered to the output buffer.
  - The FSM returns to IDLE and bit_cnt returns to 0 next cycle.
- Buffer load: the word loads if out_valid=0, or if out_valid && out_ready in the same cycle (the drain and the load happen together). out_data and out_valid=1 then appear one cycle after completion.
- Back-pressure: if out_valid=1 and out_ready=0 at completion, the new word is dropped, out_data keeps the old word, and overrun is set next cycle.
- Handshake:
  - out_valid clears the cycle after out_valid && out_ready, unless a load happens in the same cycle.
  - out_data must not change while out_valid=1 && out_ready=0.
- frame_start during SHIFT: aborts the current frame. bit_cnt=0, the partial sreg contents are discarded (sreg cleared to 0), and the FSM stays in SHIFT.
  - If frame_start and the completing bit arrive in the same cycle, frame_start wins: no word is produced and a new frame starts.
- Overrun flag:
  - If clr_overrun and a new overrun event occur in the same cycle, the set wins and overrun stays 1.
  - clr_overrun alone clears overrun next cycle.
- bit_valid with no frame armed never alters sreg or bit_cnt.
- There are no combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8. frame_start, then bits 1,0,1,1,0,0,1,0 with bit_valid=1 on consecutive cycles, out_ready=1 -> out_data=8'hB2 and out_valid=1 exactly one cycle after the 8th bit. out_valid drops the following cycle. busy=0 after completion.
- Same frame with bit_valid gaps (idle cycles between bits) -> identical 8'hB2. bit_cnt steps 0..7 only on valid cycles. No output before the 8th valid bit.
- Back-pressure: hold out_ready=0 and send frame 8'hB2, then frame 8'h5A -> out_data stays 8'hB2 and overrun=1 after the second frame. Then raise out_ready -> one handshake of 8'hB2 only. Then clr_overrun -> overrun=0.
- Simultaneous drain and load: out_valid=1 holding 8'h11, with out_ready=1 in the completion cycle of frame 8'h22 -> 8'h11 is consumed, out_data=8'h22 and out_valid stays 1 next cycle, overrun remains 0.
- Abort: frame_start, 5 bits, frame_start again, then bits for 8'hC3 -> out_data=8'hC3. Repeat with frame_start coincident with the 8th bit -> no out_valid, busy stays 1, bit_cnt=0.
- Reset: rst_n=0 for one cycle mid-frame (bit_cnt=4) with out_valid=1 -> all outputs 0 next cycle. The subsequent frame 8'hFF completes normally.
